// File: rtl/ov_stream_capture.sv
// Camera capture front end: pairs OV7670-style bytes into 16-bit YCbCr 4:2:2 words
// with X/Y coordinates, crop window, frame decimation, snapshot and stop-at-frame-end control.
module ov_stream_capture #(
    parameter int DATA_W  = 8,
    parameter int X_W     = 11,
    parameter int Y_W     = 10,
    parameter int FRAME_W = 32
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic [DATA_W-1:0]     iDATA,
    input  logic                  iFVAL,
    input  logic                  iLVAL,
    input  logic                  iSTART,
    input  logic                  iSNAP,
    input  logic                  iEND,
    input  logic                  iSWAP,
    input  logic [3:0]            iDECIM,
    input  logic [X_W-1:0]        iX0,
    input  logic [X_W-1:0]        iX1,
    input  logic [Y_W-1:0]        iY0,
    input  logic [Y_W-1:0]        iY1,
    output logic [2*DATA_W-1:0]   oPIX,
    output logic                  oDVAL,
    output logic                  oSOF,
    output logic [X_W-1:0]        oX_Cont,
    output logic [Y_W-1:0]        oY_Cont,
    output logic [FRAME_W-1:0]    oFrame_Cont,
    output logic                  oBUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SKIP  = 2'd2,
        CAPT  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 single_q, single_d;
    logic                 stopReq_q, stopReq_d;
    logic [3:0]           dcnt_q, dcnt_d;
    logic                 fval_q, lval_q;
    logic                 phase_q, phase_d;
    logic [DATA_W-1:0]    latch_q, latch_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic                 linePix_q, linePix_d;
    logic                 sofPend_q, sofPend_d;
    logic [2*DATA_W-1:0]  pix_q, pix_d;
    logic                 dval_q, dval_d;
    logic                 sof_q, sof_d;
    logic [X_W-1:0]       xOut_q, xOut_d;
    logic [Y_W-1:0]       yOut_q, yOut_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 busy_q;

    logic                 fvalRise, fvalFall, lvalFall;
    logic                 byteEn, inCrop;
    logic [2*DATA_W-1:0]  pixWord;

    assign fvalRise = iFVAL & ~fval_q;
    assign fvalFall = ~iFVAL & fval_q;
    assign lvalFall = ~iLVAL & lval_q;
    assign byteEn   = (state_q == CAPT) & iLVAL;
    assign inCrop   = (x_q >= iX0) && (x_q <= iX1) && (y_q >= iY0) && (y_q <= iY1);
    assign pixWord  = iSWAP ? {iDATA, latch_q} : {latch_q, iDATA};

    always_comb begin
        state_d   = state_q;
        single_d  = single_q;
        stopReq_d = stopReq_q;
        dcnt_d    = dcnt_q;
        frame_d   = frame_q;

        case (state_q)
            IDLE: begin
                if (!iEND && (iSTART || iSNAP)) begin
                    state_d  = ARMED;
                    single_d = ~iSTART;
                end
            end
            ARMED: begin
                if (iSNAP) single_d = 1'b1;
                if (iEND) begin
                    state_d = IDLE;
                end else if (fvalRise) begin
                    if (dcnt_q == iDECIM) begin
                        state_d = CAPT;
                        dcnt_d  = 4'd0;
                    end else begin
                        state_d = SKIP;
                        dcnt_d  = dcnt_q + 4'd1;
                    end
                end
            end
            default: begin
                if (iEND) stopReq_d = 1'b1;
                if (fvalFall) begin
                    if (state_q == CAPT) frame_d = frame_q + FRAME_W'(1);
                    if ((single_q && (state_q == CAPT)) || stopReq_d) state_d = IDLE;
                    else state_d = ARMED;
                end
            end
        endcase

        if (state_d == IDLE) stopReq_d = 1'b0;
    end

    // Byte pairing, coordinate counters and the crop-gated output word.
    always_comb begin
        phase_d   = phase_q;
        latch_d   = latch_q;
        x_d       = x_q;
        y_d       = y_q;
        linePix_d = linePix_q;
        sofPend_d = sofPend_q;
        pix_d     = pix_q;
        xOut_d    = xOut_q;
        yOut_d    = yOut_q;
        dval_d    = 1'b0;
        sof_d     = 1'b0;

        if (byteEn) begin
            if (!phase_q) begin
                latch_d = iDATA;
                phase_d = 1'b1;
            end else begin
                phase_d   = 1'b0;
                pix_d     = pixWord;
                xOut_d    = x_q;
                yOut_d    = y_q;
                dval_d    = inCrop;
                sof_d     = inCrop & sofPend_q;
                linePix_d = 1'b1;
                if (inCrop) sofPend_d = 1'b0;
                if (x_q != '1) x_d = x_q + X_W'(1);
            end
        end

        if (lvalFall) begin
            phase_d   = 1'b0;
            x_d       = '0;
            linePix_d = 1'b0;
            if (linePix_q && (y_q != '1)) y_d = y_q + Y_W'(1);
        end

        if (fvalRise) begin
            phase_d   = 1'b0;
            x_d       = '0;
            y_d       = '0;
            linePix_d = 1'b0;
        end

        if ((state_q != CAPT) && (state_d == CAPT)) sofPend_d = 1'b1;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= IDLE;
            single_q  <= 1'b0;
            stopReq_q <= 1'b0;
            dcnt_q    <= iDECIM;
            fval_q    <= 1'b0;
            lval_q    <= 1'b0;
            phase_q   <= 1'b0;
            latch_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            linePix_q <= 1'b0;
            sofPend_q <= 1'b0;
            pix_q     <= '0;
            dval_q    <= 1'b0;
            sof_q     <= 1'b0;
            xOut_q    <= '0;
            yOut_q    <= '0;
            frame_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            single_q  <= single_d;
            stopReq_q <= stopReq_d;
            dcnt_q    <= dcnt_d;
            fval_q    <= iFVAL;
            lval_q    <= iLVAL;
            phase_q   <= phase_d;
            latch_q   <= latch_d;
            x_q       <= x_d;
            y_q       <= y_d;
            linePix_q <= linePix_d;
            sofPend_q <= sofPend_d;
            pix_q     <= pix_d;
            dval_q    <= dval_d;
            sof_q     <= sof_d;
            xOut_q    <= xOut_d;
            yOut_q    <= yOut_d;
            frame_q   <= frame_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign oPIX        = pix_q;
    assign oDVAL       = dval_q;
    assign oSOF        = sof_q;
    assign oX_Cont     = xOut_q;
    assign oY_Cont     = yOut_q;
    assign oFrame_Cont = frame_q;
    assign oBUSY       = busy_q;

endmodule

// File: tb/tb_ov_stream_capture.sv
// Self-checking bench for ov_stream_capture: scenario table, hand-written corner sequences
// and randomized frames, all compared against a frame-level reference model.
module tb_ov_stream_capture;

    localparam int DATA_W  = 8;
    localparam int X_W     = 11;
    localparam int Y_W     = 10;
    localparam int FRAME_W = 32;

    logic                iCLK = 1'b0;
    logic                iRST = 1'b1;
    logic [DATA_W-1:0]   iDATA = '0;
    logic                iFVAL = 1'b0, iLVAL = 1'b0;
    logic                iSTART = 1'b0, iSNAP = 1'b0, iEND = 1'b0, iSWAP = 1'b0;
    logic [3:0]          iDECIM = '0;
    logic [X_W-1:0]      iX0 = '0, iX1 = '1;
    logic [Y_W-1:0]      iY0 = '0, iY1 = '1;
    logic [2*DATA_W-1:0] oPIX;
    logic                oDVAL, oSOF, oBUSY;
    logic [X_W-1:0]      oX_Cont;
    logic [Y_W-1:0]      oY_Cont;
    logic [FRAME_W-1:0]  oFrame_Cont;

    always #5 iCLK = ~iCLK;

    ov_stream_capture #(.DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W), .FRAME_W(FRAME_W)) dut (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
        .iSTART(iSTART), .iSNAP(iSNAP), .iEND(iEND), .iSWAP(iSWAP), .iDECIM(iDECIM),
        .iX0(iX0), .iX1(iX1), .iY0(iY0), .iY1(iY1),
        .oPIX(oPIX), .oDVAL(oDVAL), .oSOF(oSOF), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
        .oFrame_Cont(oFrame_Cont), .oBUSY(oBUSY)
    );

    typedef struct {
        logic [15:0] pix;
        int          x;
        int          y;
        logic        sof;
    } expPix_t;

    typedef struct {
        string name;
        int    decim;
        int    swap;
        int    x0, x1, y0, y1;
        int    nLines, nBytes, nFrames, dataMode;
        int    expPulses, expFrames;
    } vec_t;

    expPix_t     expQ[$];
    expPix_t     monE;
    vec_t        vecs[5];
    int          compares = 0;
    int          errors = 0;
    int          dvalCount = 0;
    bit          monitorOn = 1'b0;

    bit          mArmed, mInFrame, mCapt, mSingle, mStop;
    int          mSeen, mDecim;
    int unsigned mFrames;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compares++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelStart();
        if (!mArmed && !mInFrame) begin
            mArmed  = 1'b1;
            mSingle = 1'b0;
        end
    endfunction

    function automatic void modelSnap();
        if (!mArmed && !mInFrame) begin
            mArmed  = 1'b1;
            mSingle = 1'b1;
        end else if (mArmed) begin
            mSingle = 1'b1;
        end
    endfunction

    function automatic void modelEnd();
        if (mArmed) mArmed = 1'b0;
        else if (mInFrame) mStop = 1'b1;
    endfunction

    function automatic void modelRise();
        if (mArmed) begin
            mArmed   = 1'b0;
            mInFrame = 1'b1;
            mCapt    = (mSeen % (mDecim + 1)) == 0;
            mSeen++;
        end
    endfunction

    function automatic void modelFall();
        if (mInFrame) begin
            mInFrame = 1'b0;
            if (mCapt) mFrames++;
            if ((mSingle && mCapt) || mStop) mStop = 1'b0;
            else mArmed = 1'b1;
        end
    endfunction

    // Outputs are sampled on the falling edge, half a period away from the capture edge.
    always @(negedge iCLK) begin
        if (monitorOn) begin
            if (oDVAL) begin
                dvalCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected oDVAL", 64'(oDVAL), 64'd0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("oPIX", 64'(oPIX), 64'(monE.pix));
                    checkOutput("oX_Cont", 64'(oX_Cont), 64'(monE.x));
                    checkOutput("oY_Cont", 64'(oY_Cont), 64'(monE.y));
                    checkOutput("oSOF", 64'(oSOF), 64'(monE.sof));
                end
            end else if (oSOF) begin
                checkOutput("oSOF without oDVAL", 64'(oSOF), 64'd0);
            end
        end
    end

    task automatic doReset();
        iRST = 1'b1; iSTART = 1'b0; iSNAP = 1'b0; iEND = 1'b0;
        iFVAL = 1'b0; iLVAL = 1'b0; iDATA = '0;
        tick();
        tick();
        iRST = 1'b0;
        mArmed = 0; mInFrame = 0; mCapt = 0; mSingle = 0; mStop = 0;
        mSeen = 0; mFrames = 0; mDecim = int'(iDECIM);
        expQ.delete();
    endtask

    task automatic pulseStart();
        iSTART = 1'b1; modelStart(); tick(); iSTART = 1'b0;
    endtask

    task automatic pulseSnap();
        iSNAP = 1'b1; modelSnap(); tick(); iSNAP = 1'b0;
    endtask

    task automatic pulseEnd();
        iEND = 1'b1; modelEnd(); tick(); iEND = 1'b0;
    endtask

    // One frame; fixedLen = 0 picks a random byte count per line, endLine < 0 means no iEND.
    task automatic sendFrame(input int nLines, input int fixedLen, input int dataMode, input int endLine);
        logic [7:0] b [16];
        int         nb, yLine, v;
        bit         sofPend;
        expPix_t    e;
        modelRise();
        iFVAL = 1'b1;
        tick(); tick(); tick();
        yLine   = 0;
        sofPend = mInFrame && mCapt;
        for (int ln = 0; ln < nLines; ln++) begin
            nb = (fixedLen > 0) ? fixedLen : int'($urandom_range(1, 12));
            for (int i = 0; i < nb; i++) begin
                v = (dataMode == 0) ? i : (dataMode == 1) ? (161 + 17 * i) : int'($urandom_range(0, 255));
                b[i] = v[7:0];
            end
            if (mInFrame && mCapt) begin
                for (int k = 0; k < nb / 2; k++) begin
                    e.pix = iSWAP ? {b[2*k+1], b[2*k]} : {b[2*k], b[2*k+1]};
                    e.x   = k;
                    e.y   = yLine;
                    e.sof = 1'b0;
                    if (k >= int'(iX0) && k <= int'(iX1) && yLine >= int'(iY0) && yLine <= int'(iY1)) begin
                        e.sof   = sofPend;
                        sofPend = 1'b0;
                        expQ.push_back(e);
                    end
                end
                if (nb >= 2) yLine++;
            end
            for (int i = 0; i < nb; i++) begin
                iLVAL = 1'b1;
                iDATA = b[i];
                iEND  = (ln == endLine) && (i == 0);
                if (iEND) modelEnd();
                tick();
            end
            iEND = 1'b0; iLVAL = 1'b0; iDATA = '0;
            tick(); tick();
        end
        iFVAL = 1'b0;
        tick();
        modelFall();
        @(negedge iCLK);
        checkOutput("oFrame_Cont at frame end", 64'(oFrame_Cont), 64'(mFrames));
        checkOutput("oBUSY at frame end", 64'(oBUSY), 64'(mArmed || mInFrame));
        checkOutput("missing pixels", 64'(expQ.size()), 64'd0);
        tick();
    endtask

    task automatic applyStimulus(input vec_t v);
        iDECIM = 4'(v.decim);
        iSWAP  = v.swap[0];
        iX0 = X_W'(v.x0); iX1 = X_W'(v.x1);
        iY0 = Y_W'(v.y0); iY1 = Y_W'(v.y1);
        doReset();
        dvalCount = 0;
        pulseStart();
        for (int f = 0; f < v.nFrames; f++) sendFrame(v.nLines, v.nBytes, v.dataMode, -1);
        checkOutput({v.name, " pulse count"}, 64'(dvalCount), 64'(v.expPulses));
        checkOutput({v.name, " frame count"}, 64'(oFrame_Cont), 64'(v.expFrames));
    endtask

    initial begin
        vecs[0] = '{"basic",      0, 0, 0, 2047, 0, 1023, 2,  8, 1, 0, 8, 1};
        vecs[1] = '{"swap_odd",   0, 1, 0, 2047, 0, 1023, 2,  5, 1, 1, 4, 1};
        vecs[2] = '{"crop",       0, 0, 2, 3,    1, 2,    4, 16, 1, 0, 4, 1};
        vecs[3] = '{"decim",      2, 0, 0, 2047, 0, 1023, 1,  4, 7, 0, 6, 3};
        vecs[4] = '{"crop_empty", 0, 0, 5, 2,    0, 1023, 2,  8, 1, 0, 0, 1};

        doReset();
        @(negedge iCLK);
        checkOutput("reset oPIX", 64'(oPIX), 64'd0);
        checkOutput("reset oDVAL", 64'(oDVAL), 64'd0);
        checkOutput("reset oSOF", 64'(oSOF), 64'd0);
        checkOutput("reset oX_Cont", 64'(oX_Cont), 64'd0);
        checkOutput("reset oY_Cont", 64'(oY_Cont), 64'd0);
        checkOutput("reset oFrame_Cont", 64'(oFrame_Cont), 64'd0);
        checkOutput("reset oBUSY", 64'(oBUSY), 64'd0);
        monitorOn = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Snapshot captures only the first frame, then a stop request mid-frame lets it finish.
        iDECIM = 4'd0; iSWAP = 1'b0;
        iX0 = '0; iX1 = '1; iY0 = '0; iY1 = '1;
        doReset();
        dvalCount = 0;
        pulseSnap();
        for (int f = 0; f < 3; f++) sendFrame(1, 4, 0, -1);
        checkOutput("snap frame count", 64'(oFrame_Cont), 64'd1);
        checkOutput("snap pulse count", 64'(dvalCount), 64'd2);
        pulseStart();
        sendFrame(3, 6, 0, 1);
        sendFrame(1, 4, 0, -1);
        checkOutput("stop frame count", 64'(oFrame_Cont), 64'd2);
        checkOutput("stop pulse count", 64'(dvalCount), 64'd11);
        checkOutput("stop oBUSY", 64'(oBUSY), 64'd0);

        // iSTART together with iEND must leave the block idle.
        doReset();
        dvalCount = 0;
        iSTART = 1'b1; iEND = 1'b1;
        tick();
        iSTART = 1'b0; iEND = 1'b0;
        @(negedge iCLK);
        checkOutput("start+end oBUSY", 64'(oBUSY), 64'd0);
        sendFrame(1, 4, 0, -1);
        checkOutput("start+end pulse count", 64'(dvalCount), 64'd0);

        // Reset in the middle of a line, then arming while that frame is still high.
        doReset();
        monitorOn = 1'b0;
        iSTART = 1'b1; tick(); iSTART = 1'b0;
        iFVAL = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            iLVAL = 1'b1; iDATA = 8'(8'h30 + i); tick();
        end
        iRST = 1'b1; iDATA = 8'h55;
        tick();
        iRST = 1'b0;
        @(negedge iCLK);
        checkOutput("mid-line reset oDVAL", 64'(oDVAL), 64'd0);
        checkOutput("mid-line reset oPIX", 64'(oPIX), 64'd0);
        checkOutput("mid-line reset oX_Cont", 64'(oX_Cont), 64'd0);
        checkOutput("mid-line reset oBUSY", 64'(oBUSY), 64'd0);
        mArmed = 0; mInFrame = 0; mStop = 0; mSingle = 0; mSeen = 0; mFrames = 0;
        expQ.delete();
        dvalCount = 0;
        monitorOn = 1'b1;
        pulseStart();
        for (int i = 0; i < 6; i++) begin
            iDATA = 8'(i); tick();
        end
        iLVAL = 1'b0; tick(); tick();
        iFVAL = 1'b0; tick();
        @(negedge iCLK);
        checkOutput("in-progress frame pulses", 64'(dvalCount), 64'd0);
        checkOutput("in-progress frame oBUSY", 64'(oBUSY), 64'd1);
        sendFrame(1, 4, 0, -1);
        checkOutput("after in-progress frame count", 64'(oFrame_Cont), 64'd1);

        // Randomized traffic with random controls between frames.
        for (int seg = 0; seg < 3; seg++) begin
            iDECIM = 4'($urandom_range(0, 3));
            iX0 = X_W'($urandom_range(0, 3)); iX1 = X_W'($urandom_range(0, 6));
            iY0 = Y_W'($urandom_range(0, 1)); iY1 = Y_W'($urandom_range(0, 3));
            doReset();
            pulseStart();
            for (int f = 0; f < 10; f++) begin
                case ($urandom_range(0, 9))
                    0: pulseStart();
                    1: pulseSnap();
                    2: pulseEnd();
                    default: tick();
                endcase
                iSWAP = 1'($urandom_range(0, 1));
                sendFrame(int'($urandom_range(1, 4)), 0, 2, ($urandom_range(0, 5) == 0) ? 0 : -1);
            end
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
